// File: rtl/cap_sense_scanner_pkg.sv
// Shared definitions for the capacitive pad scanner: FSM encoding and default constants,
// kept in one place so the scanner and the processor-side register decode agree.
package cap_sense_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISCHARGE = 2'd1,
    CHARGE    = 2'd2,
    EVAL      = 2'd3
  } state_t;

  localparam int DEF_N_SENSORS        = 9;
  localparam int DEF_CNT_W            = 16;
  localparam int DEF_DISCHARGE_CYCLES = 256;
  localparam int DEF_TIMEOUT          = 4095;
  localparam int DEF_THRESHOLD        = 200;
  localparam int DEF_DEBOUNCE         = 3;
  localparam int RD_SEL_W             = 4;

endpackage

// File: rtl/cap_sense_scanner_if.sv
// Processor-side view of the scanner: run control, touch state, sticky hits and count read port.
interface cap_sense_scanner_if
  import cap_sense_scanner_pkg::*;
#(
  parameter int N_SENSORS = DEF_N_SENSORS,
  parameter int CNT_W     = DEF_CNT_W
);

  logic                 enable;
  logic [N_SENSORS-1:0] touched;
  logic [N_SENSORS-1:0] hit_sticky;
  logic [N_SENSORS-1:0] hit_clear;
  logic                 sweep_done;
  logic [RD_SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]     rd_count;

  // No valid/ready pair: sweep_done is a one-cycle strobe with no backpressure, rd_count is a
  // combinational read of rd_sel that stays stable between strobes, and hit_clear is level-sampled.
  modport master (
    output enable, hit_clear, rd_sel,
    input  touched, hit_sticky, sweep_done, rd_count
  );

  modport slave (
    input  enable, hit_clear, rd_sel,
    output touched, hit_sticky, sweep_done, rd_count
  );

endinterface

// File: rtl/cap_sense_scanner_debounce.sv
// Per-pad debounce across sweeps plus the sticky hit flag raised on a debounced touch.
module cap_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic eval,
  input  logic raw,
  input  logic hit_clear,
  output logic touched,
  output logic hit_sticky
);

  localparam int DBC_W = $clog2(DEBOUNCE + 1);

  logic [DBC_W-1:0] dbc;
  logic             last_agree;
  logic             hit_set;

  assign last_agree = (dbc == DBC_W'(DEBOUNCE - 1));
  assign hit_set    = eval && raw && !touched && last_agree;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dbc        <= '0;
      touched    <= 1'b0;
      hit_sticky <= 1'b0;
    end else begin
      if (eval) begin
        if (raw == touched) begin
          dbc <= '0;
        end else if (last_agree) begin
          touched <= raw;
          dbc     <= '0;
        end else begin
          dbc <= dbc + 1'b1;
        end
      end
      // A new touch beats a clear arriving on the same edge.
      if (hit_set)        hit_sticky <= 1'b1;
      else if (hit_clear) hit_sticky <= 1'b0;
    end
  end

endmodule

// File: rtl/cap_sense_scanner.sv
// Drives the shared sensor pin, times each pad's RC rise per sweep and publishes counts
// and debounced touch state to the processor.
module cap_sense_scanner
  import cap_sense_scanner_pkg::*;
#(
  parameter int N_SENSORS        = DEF_N_SENSORS,
  parameter int CNT_W            = DEF_CNT_W,
  parameter int DISCHARGE_CYCLES = DEF_DISCHARGE_CYCLES,
  parameter int TIMEOUT          = DEF_TIMEOUT,
  parameter int THRESHOLD        = DEF_THRESHOLD,
  parameter int DEBOUNCE         = DEF_DEBOUNCE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_SENSORS-1:0]  sense_in,
  output logic                  drive_out,
  output state_t                state_dbg,
  cap_sense_scanner_if.slave    bus
);

  state_t                          state, state_nx;
  logic [N_SENSORS-1:0]            ss_meta, ss, latched, raw;
  logic [N_SENSORS-1:0]            touched_v, hit_v;
  logic [N_SENSORS-1:0][CNT_W-1:0] rise, count;
  logic [CNT_W-1:0]                timer, rd_count_v;
  logic                            charge_done, sweep_done_v;

  assign charge_done = (&(latched | ss)) || (timer == CNT_W'(TIMEOUT));

  always_comb begin
    state_nx     = state;
    drive_out    = 1'b0;
    sweep_done_v = 1'b0;
    case (state)
      IDLE:      if (bus.enable) state_nx = DISCHARGE;
      DISCHARGE: if (timer == CNT_W'(DISCHARGE_CYCLES - 1)) state_nx = CHARGE;
      CHARGE: begin
        drive_out = 1'b1;
        if (charge_done) state_nx = EVAL;
      end
      EVAL: begin
        sweep_done_v = 1'b1;
        state_nx     = bus.enable ? DISCHARGE : IDLE;
      end
      default:   state_nx = IDLE;
    endcase
  end

  // One timer serves as the discharge counter and the charge timer; it restarts on every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      ss_meta <= '0;
      ss      <= '0;
      latched <= '0;
      rise    <= '0;
      count   <= '0;
    end else begin
      ss_meta <= sense_in;
      ss      <= ss_meta;
      state   <= state_nx;
      timer   <= (state_nx != state || state == IDLE) ? '0 : timer + 1'b1;
      case (state)
        DISCHARGE: latched <= '0;
        CHARGE: begin
          for (int i = 0; i < N_SENSORS; i++) begin
            if (!latched[i]) begin
              if (ss[i]) begin
                rise[i]    <= timer;
                latched[i] <= 1'b1;
              end else if (charge_done) begin
                rise[i] <= CNT_W'(TIMEOUT);
              end
            end
          end
        end
        EVAL:    count <= rise;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_pad
    assign raw[g] = (rise[g] > CNT_W'(THRESHOLD));

    cap_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clock      (clock),
      .reset      (reset),
      .eval       (state == EVAL),
      .raw        (raw[g]),
      .hit_clear  (bus.hit_clear[g]),
      .touched    (touched_v[g]),
      .hit_sticky (hit_v[g])
    );
  end

  always_comb begin
    rd_count_v = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (bus.rd_sel == RD_SEL_W'(i)) rd_count_v = count[i];
    end
  end

  assign bus.touched    = touched_v;
  assign bus.hit_sticky = hit_v;
  assign bus.sweep_done = sweep_done_v;
  assign bus.rd_count   = rd_count_v;
  assign state_dbg      = state;

endmodule

// File: tb/tb_cap_sense_scanner.sv
// Bench for cap_sense_scanner: an RC pad model plus a per-sweep vector table checked at each sweep end.
module tb_cap_sense_scanner;
  import cap_sense_scanner_pkg::*;

  localparam int N  = 9;
  localparam int CW = 16;
  localparam int DC = 4;
  localparam int TO = 63;
  localparam int TH = 20;
  localparam int DB = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] sense_in;
  logic         drive_out;
  state_t       state_dbg;

  cap_sense_scanner_if #(.N_SENSORS(N), .CNT_W(CW)) bus ();

  cap_sense_scanner #(
    .N_SENSORS(N), .CNT_W(CW), .DISCHARGE_CYCLES(DC),
    .TIMEOUT(TO), .THRESHOLD(TH), .DEBOUNCE(DB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sense_in  (sense_in),
    .drive_out (drive_out),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // clock / reset
  always #20 clock = ~clock;

  // pad model: pad i goes high delay[i] cycles after drive_out rises; also measures drive phases
  int delay [N];
  int ch_cnt = 0;
  int hi_cnt = 0, lo_cnt = 0, last_charge = 0, last_gap = 0;

  always @(negedge clock) begin
    if (drive_out) begin
      if (hi_cnt == 0) last_gap = lo_cnt;
      hi_cnt++;
      lo_cnt = 0;
      ch_cnt++;
    end else begin
      if (hi_cnt != 0) last_charge = hi_cnt;
      hi_cnt = 0;
      lo_cnt++;
      ch_cnt = 0;
    end
    for (int i = 0; i < N; i++) sense_in[i] = (ch_cnt > delay[i]);
  end

  // scoreboard
  logic [CW-1:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_sweep(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (bus.sweep_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drive(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (drive_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] slow;      // rise after 30 cycles
    logic [N-1:0] never;     // never rises
    logic         rand_fast; // fast pads take a random 0..10 delay instead of 5
    logic [N-1:0] clr;       // hit_clear applied during this sweep's EVAL cycle
    logic [N-1:0] exp_t;
    logic [N-1:0] exp_h;
  } vec_t;

  vec_t tbl [7];

  initial begin
    bit ok;
    int lows, dones, mx, cnt;

    tbl[0] = '{9'h000, 9'h000, 1'b0, 9'h000, 9'h000, 9'h000};
    tbl[1] = '{9'h008, 9'h000, 1'b0, 9'h000, 9'h000, 9'h000};
    tbl[2] = '{9'h000, 9'h000, 1'b1, 9'h000, 9'h000, 9'h000};
    tbl[3] = '{9'h008, 9'h000, 1'b1, 9'h000, 9'h000, 9'h000};
    tbl[4] = '{9'h008, 9'h000, 1'b1, 9'h008, 9'h008, 9'h008};
    tbl[5] = '{9'h008, 9'h001, 1'b0, 9'h008, 9'h008, 9'h000};
    tbl[6] = '{9'h008, 9'h001, 1'b0, 9'h000, 9'h009, 9'h001};

    for (int i = 0; i < N; i++) delay[i] = 5;
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.hit_clear = '0;
    bus.rd_sel    = '0;
    repeat (3) @(negedge clock);
    check("rst_drive", 32'(drive_out), 0);
    check("rst_touched", 32'(bus.touched), 0);
    check("rst_hit", 32'(bus.hit_sticky), 0);
    check("rst_sweep_done", 32'(bus.sweep_done), 0);
    check("rst_rd_count", 32'(bus.rd_count), 0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    @(negedge clock);

    for (int v = 0; v < 7; v++) begin
      mx = 0;
      for (int i = 0; i < N; i++) begin
        if (tbl[v].never[i])      delay[i] = 1000;
        else if (tbl[v].slow[i])  delay[i] = 30;
        else if (tbl[v].rand_fast) delay[i] = int'($urandom_range(0, 10));
        else                      delay[i] = 5;
        cnt = (delay[i] + 2 > TO) ? TO : delay[i] + 2;
        if (cnt > mx) mx = cnt;
        exp_q.push_back(CW'(cnt));
      end

      if (v == 0) begin
        bus.enable = 1'b1;
        lows = 0;
        ok   = 1'b0;
        for (int c = 0; c < 50; c++) begin
          @(negedge clock);
          if (drive_out) begin
            ok = 1'b1;
            break;
          end
          lows++;
        end
        check("first_drive_rise", 32'(ok), 1);
        check("discharge_low_cycles", 32'(lows), DC);
      end

      wait_sweep(ok);
      check($sformatf("sweep%0d_done", v), 32'(ok), 1);
      bus.hit_clear = tbl[v].clr;
      @(negedge clock);
      bus.hit_clear = '0;
      check($sformatf("sweep%0d_done_pulse", v), 32'(bus.sweep_done), 0);
      check($sformatf("sweep%0d_touched", v), 32'(bus.touched), 32'(tbl[v].exp_t));
      check($sformatf("sweep%0d_hit", v), 32'(bus.hit_sticky), 32'(tbl[v].exp_h));
      check($sformatf("sweep%0d_charge_len", v), 32'(last_charge), 32'(mx + 1));
      if (v > 0) check($sformatf("sweep%0d_low_gap", v), 32'(last_gap), DC + 1);
      for (int i = 0; i < N; i++) begin
        bus.rd_sel = 4'(i);
        #1;
        check($sformatf("sweep%0d_count%0d", v, i), 32'(bus.rd_count), 32'(exp_q.pop_front()));
      end
      if (v == 0) begin
        bus.rd_sel = 4'd12;
        #1;
        check("rd_sel_out_of_range", 32'(bus.rd_count), 0);
      end
    end
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    // enable dropped mid-CHARGE: that sweep still finishes, then the FSM parks in IDLE
    wait_drive(ok);
    check("drop_drive_seen", 32'(ok), 1);
    repeat (2) @(negedge clock);
    bus.enable = 1'b0;
    dones = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clock);
      if (bus.sweep_done) dones++;
    end
    check("drop_sweep_count", 32'(dones), 1);
    check("drop_state", 32'(state_dbg), 32'(IDLE));
    check("drop_drive", 32'(drive_out), 0);
    check("drop_touched_kept", 32'(bus.touched), 32'h009);

    // reset mid-CHARGE: everything clears without waiting for a clock edge
    bus.enable = 1'b1;
    wait_drive(ok);
    check("rst_drive_seen", 32'(ok), 1);
    repeat (3) @(negedge clock);
    #5 reset = 1'b1;
    #1;
    check("midrst_drive", 32'(drive_out), 0);
    check("midrst_touched", 32'(bus.touched), 0);
    check("midrst_hit", 32'(bus.hit_sticky), 0);
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    bus.enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_rd_count", 32'(bus.rd_count), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
